// File: rtl/mshr_file_pkg.sv
// Shared types for the miss status holding register file: memory bus
// encodings, the per-entry state enum and the entry record.
package mshr_file_pkg;

    localparam int ADDR_W             = 32;
    localparam int DATA_W             = 32;
    localparam int BLOCK_W            = 64;
    localparam int TAG_W              = 4;
    localparam int MSHR_DEPTH_DEFAULT = 4;

    typedef logic [ADDR_W-1:0]  ADDR;
    typedef logic [DATA_W-1:0]  DATA;
    typedef logic [BLOCK_W-1:0] MEM_BLOCK;
    typedef logic [TAG_W-1:0]   MEM_TAG;

    typedef enum logic [1:0] {
        BYTE   = 2'h0,
        HALF   = 2'h1,
        WORD   = 2'h2,
        DOUBLE = 2'h3
    } MEM_SIZE;

    typedef enum logic [1:0] {
        MEM_NONE  = 2'h0,
        MEM_LOAD  = 2'h1,
        MEM_STORE = 2'h2
    } MEM_COMMAND;

    typedef enum logic [1:0] {
        MSHR_INVALID = 2'h0,
        MSHR_PENDING = 2'h1,
        MSHR_WAITING = 2'h2
    } MSHR_STATE;

    typedef struct packed {
        MSHR_STATE state;
        ADDR       block_addr;
        ADDR       byte_addr;
        logic      is_store;
        DATA       st_data;
        MEM_SIZE   st_size;
        MEM_TAG    mem_tag;
    } MSHR_ENTRY;

    // Clears the byte-offset bits so the address names the whole block.
    function automatic ADDR block_align(input ADDR addr, input int unsigned offset_bits);
        return addr & ~((ADDR'(1) << offset_bits) - ADDR'(1));
    endfunction

endpackage

// File: rtl/mshr_file_lsb_select.sv
// Lowest-set-bit picker: one-hot of the lowest requesting bit plus an
// any-request flag. Used for free-slot allocation and issue arbitration.
module mshr_lsb_select #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_req,
    output logic [WIDTH-1:0] o_onehot,
    output logic             o_valid
);

    // Two's-complement trick isolates the lowest set bit.
    always_comb begin
        o_onehot = i_req & (~i_req + WIDTH'(1));
        o_valid  = |i_req;
    end

endmodule

// File: rtl/mshr_file.sv
// Non-blocking miss status holding register file between D-cache and memory.
//
// Per-entry state table:
//   state        | meaning
//   MSHR_INVALID | slot free, may be allocated
//   MSHR_PENDING | miss recorded, memory load not yet accepted
//   MSHR_WAITING | load accepted by memory, holding its transaction tag
//
// A slot freed by a fill is still WAITING in the registered state during the
// fill cycle, so it only becomes allocatable the cycle after.
module mshr_file
    import mshr_file_pkg::*;
#(
    parameter int MSHR_DEPTH        = MSHR_DEPTH_DEFAULT,
    parameter int BLOCK_OFFSET_BITS = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       req_valid,
    input  ADDR        req_addr,
    input  logic       req_is_store,
    input  DATA        req_data,
    input  MEM_SIZE    req_size,
    output logic       req_ready,
    output MEM_COMMAND proc2mem_command,
    output ADDR        proc2mem_addr,
    input  MEM_TAG     mem2proc_transaction_tag,
    input  MEM_TAG     mem2proc_data_tag,
    input  MEM_BLOCK   mem2proc_data,
    output logic       fill_valid,
    output ADDR        fill_addr,
    output MEM_BLOCK   fill_data,
    output logic       fill_is_store,
    output ADDR        fill_st_addr,
    output DATA        fill_st_data,
    output MEM_SIZE    fill_st_size,
    output logic       full,
    output logic       stall
`ifdef DEBUG
    ,
    output MSHR_ENTRY  debug_entries [MSHR_DEPTH]
`endif
);

    MSHR_ENTRY r_entries [MSHR_DEPTH];

    logic [MSHR_DEPTH-1:0] w_fill_hit;
    logic [MSHR_DEPTH-1:0] w_match;
    logic [MSHR_DEPTH-1:0] w_free_vec;
    logic [MSHR_DEPTH-1:0] w_pend_vec;
    logic [MSHR_DEPTH-1:0] w_free_onehot;
    logic [MSHR_DEPTH-1:0] w_issue_onehot;
    logic [MSHR_DEPTH-1:0] w_alloc_onehot;
    logic                  w_free_valid;
    logic                  w_issue_valid;
    logic                  w_issue_fire;
    logic                  w_any_match;
    logic                  w_alloc;
    ADDR                   w_issue_addr;
    logic                  w_fill_valid;
    ADDR                   w_fill_block_addr;
    ADDR                   w_fill_byte_addr;
    logic                  w_fill_is_store;
    DATA                   w_fill_st_data;
    MEM_SIZE               w_fill_st_size;

    // Per-entry status vectors: retiring, block match, free and pending.
    always_comb begin
        for (int i = 0; i < MSHR_DEPTH; i++) begin
            w_fill_hit[i] = (r_entries[i].state == MSHR_WAITING) &&
                            (mem2proc_data_tag != '0) &&
                            (r_entries[i].mem_tag == mem2proc_data_tag);
            w_match[i]    = (r_entries[i].state != MSHR_INVALID) && !w_fill_hit[i] &&
                            (r_entries[i].block_addr[ADDR_W-1:BLOCK_OFFSET_BITS] ==
                             req_addr[ADDR_W-1:BLOCK_OFFSET_BITS]);
            w_free_vec[i] = (r_entries[i].state == MSHR_INVALID);
            w_pend_vec[i] = (r_entries[i].state == MSHR_PENDING);
        end
    end

    mshr_lsb_select #(.WIDTH(MSHR_DEPTH)) u_free_sel (
        .i_req    (w_free_vec),
        .o_onehot (w_free_onehot),
        .o_valid  (w_free_valid)
    );

    mshr_lsb_select #(.WIDTH(MSHR_DEPTH)) u_issue_sel (
        .i_req    (w_pend_vec),
        .o_onehot (w_issue_onehot),
        .o_valid  (w_issue_valid)
    );

    // Request acceptance: loads merge into a live block, stores wait for it to retire.
    always_comb begin
        w_any_match    = |w_match;
        w_alloc        = req_valid && !w_any_match && w_free_valid;
        w_alloc_onehot = w_free_onehot & {MSHR_DEPTH{w_alloc}};
        req_ready      = req_valid && (w_any_match ? !req_is_store : w_free_valid);
        stall          = req_valid && !req_ready;
        full           = ~|w_free_vec;
    end

    // Issue the lowest pending entry; it only advances if memory returns a tag.
    always_comb begin
        w_issue_addr = '0;
        for (int i = 0; i < MSHR_DEPTH; i++) begin
            if (w_issue_onehot[i]) begin
                w_issue_addr = r_entries[i].block_addr;
            end
        end
        w_issue_fire     = w_issue_valid && (mem2proc_transaction_tag != '0);
        proc2mem_command = w_issue_valid ? MEM_LOAD : MEM_NONE;
        proc2mem_addr    = w_issue_addr;
    end

    // Fill mux; tags are unique among waiting entries, lowest index wins regardless.
    always_comb begin
        w_fill_valid      = 1'b0;
        w_fill_block_addr = '0;
        w_fill_byte_addr  = '0;
        w_fill_is_store   = 1'b0;
        w_fill_st_data    = '0;
        w_fill_st_size    = BYTE;
        for (int i = MSHR_DEPTH - 1; i >= 0; i--) begin
            if (w_fill_hit[i]) begin
                w_fill_valid      = 1'b1;
                w_fill_block_addr = r_entries[i].block_addr;
                w_fill_byte_addr  = r_entries[i].byte_addr;
                w_fill_is_store   = r_entries[i].is_store;
                w_fill_st_data    = r_entries[i].st_data;
                w_fill_st_size    = r_entries[i].st_size;
            end
        end
        fill_valid    = w_fill_valid;
        fill_addr     = w_fill_block_addr;
        fill_data     = w_fill_valid ? mem2proc_data : '0;
        fill_is_store = w_fill_is_store;
        fill_st_addr  = w_fill_is_store ? w_fill_byte_addr : '0;
        fill_st_data  = w_fill_is_store ? w_fill_st_data : '0;
        fill_st_size  = w_fill_is_store ? w_fill_st_size : BYTE;
    end

    // Entry updates; fill, issue and allocate touch entries in disjoint states.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < MSHR_DEPTH; i++) begin
                r_entries[i] <= '0;
            end
        end else begin
            for (int i = 0; i < MSHR_DEPTH; i++) begin
                if (w_fill_hit[i]) begin
                    r_entries[i] <= '0;
                end else if (w_issue_onehot[i] && w_issue_fire) begin
                    r_entries[i].state   <= MSHR_WAITING;
                    r_entries[i].mem_tag <= mem2proc_transaction_tag;
                end else if (w_alloc_onehot[i]) begin
                    r_entries[i].state      <= MSHR_PENDING;
                    r_entries[i].block_addr <= block_align(req_addr, BLOCK_OFFSET_BITS);
                    r_entries[i].byte_addr  <= req_addr;
                    r_entries[i].is_store   <= req_is_store;
                    r_entries[i].st_data    <= req_is_store ? req_data : '0;
                    r_entries[i].st_size    <= req_is_store ? req_size : BYTE;
                    r_entries[i].mem_tag    <= '0;
                end
            end
        end
    end

`ifdef DEBUG
    // Expose the raw entry array for debug visibility.
    always_comb begin
        for (int i = 0; i < MSHR_DEPTH; i++) begin
            debug_entries[i] = r_entries[i];
        end
    end
`endif

endmodule

// File: tb/tb_mshr_file.sv
// Self-checking bench for mshr_file: directed vector table, hand-written
// multi-cycle sequences and a randomized run against a behavioural model.
module tb_mshr_file;
    import mshr_file_pkg::*;

    localparam int DEPTH = 4;

    logic       clock;
    logic       reset;
    logic       req_valid;
    ADDR        req_addr;
    logic       req_is_store;
    DATA        req_data;
    MEM_SIZE    req_size;
    logic       req_ready;
    MEM_COMMAND proc2mem_command;
    ADDR        proc2mem_addr;
    MEM_TAG     ttag;
    MEM_TAG     dtag;
    MEM_BLOCK   mdata;
    logic       fill_valid;
    ADDR        fill_addr;
    MEM_BLOCK   fill_data;
    logic       fill_is_store;
    ADDR        fill_st_addr;
    DATA        fill_st_data;
    MEM_SIZE    fill_st_size;
    logic       full;
    logic       stall;

    mshr_file #(.MSHR_DEPTH(DEPTH), .BLOCK_OFFSET_BITS(3)) dut (
        .clock                    (clock),
        .reset                    (reset),
        .req_valid                (req_valid),
        .req_addr                 (req_addr),
        .req_is_store             (req_is_store),
        .req_data                 (req_data),
        .req_size                 (req_size),
        .req_ready                (req_ready),
        .proc2mem_command         (proc2mem_command),
        .proc2mem_addr            (proc2mem_addr),
        .mem2proc_transaction_tag (ttag),
        .mem2proc_data_tag        (dtag),
        .mem2proc_data            (mdata),
        .fill_valid               (fill_valid),
        .fill_addr                (fill_addr),
        .fill_data                (fill_data),
        .fill_is_store            (fill_is_store),
        .fill_st_addr             (fill_st_addr),
        .fill_st_data             (fill_st_data),
        .fill_st_size             (fill_st_size),
        .full                     (full),
        .stall                    (stall)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        req_valid    = 1'b0;
        req_addr     = '0;
        req_is_store = 1'b0;
        req_data     = '0;
        req_size     = BYTE;
        ttag         = '0;
        dtag         = '0;
        mdata        = '0;
    endtask

    task automatic next();
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle();
        next();
        next();
        reset = 1'b0;
    endtask

    task automatic drive_req(input ADDR a, input logic st, input DATA d, input MEM_SIZE sz);
        req_valid    = 1'b1;
        req_addr     = a;
        req_is_store = st;
        req_data     = d;
        req_size     = sz;
    endtask

    typedef struct {
        logic       v;
        ADDR        a;
        logic       st;
        DATA        d;
        MEM_TAG     tt;
        MEM_TAG     dt;
        MEM_BLOCK   md;
        logic       e_ready;
        logic       e_stall;
        MEM_COMMAND e_cmd;
        ADDR        e_paddr;
        logic       e_fv;
        ADDR        e_faddr;
        logic       e_fst;
        ADDR        e_fsa;
        DATA        e_fsd;
        logic       e_full;
    } vec_t;

    function automatic vec_t mk(input logic v, input ADDR a, input logic st, input DATA d,
                                input MEM_TAG tt, input MEM_TAG dt,
                                input logic r, input logic stl, input logic iss, input ADDR pa,
                                input logic fv, input ADDR fa, input logic fst, input ADDR fsa,
                                input DATA fsd, input logic fl);
        vec_t x;
        x.v = v; x.a = a; x.st = st; x.d = d; x.tt = tt; x.dt = dt;
        x.md = {16'hABCD, 12'h000, dt, 32'h1234_5678};
        x.e_ready = r; x.e_stall = stl;
        x.e_cmd = iss ? MEM_LOAD : MEM_NONE;
        x.e_paddr = pa; x.e_fv = fv; x.e_faddr = fa; x.e_fst = fst;
        x.e_fsa = fsa; x.e_fsd = fsd; x.e_full = fl;
        return x;
    endfunction

    localparam int NV = 20;
    vec_t vt [NV];

    // Behavioural model state for the random run.
    int      m_state [DEPTH];   // 0 free, 1 awaiting issue, 2 awaiting data
    ADDR     m_byte  [DEPTH];
    logic    m_st    [DEPTH];
    DATA     m_data  [DEPTH];
    MEM_SIZE m_size  [DEPTH];
    MEM_TAG  m_tag   [DEPTH];

    function automatic MEM_TAG fresh_tag();
        MEM_TAG t;
        logic   ok;
        for (int a = 0; a < 32; a++) begin
            t  = MEM_TAG'($urandom_range(1, 15));
            ok = 1'b1;
            for (int i = 0; i < DEPTH; i++)
                if (m_state[i] == 2 && m_tag[i] == t) ok = 1'b0;
            if (ok) return t;
        end
        return '0;
    endfunction

    initial begin
        reset = 1'b0;
        idle();
        vt[0]  = mk(1, 32'h1004, 0, 0, 0, 0,  1, 0, 0, 0,        0, 0, 0, 0, 0, 0);
        vt[1]  = mk(0, 0, 0, 0, 3, 0,         0, 0, 1, 32'h1000, 0, 0, 0, 0, 0, 0);
        vt[2]  = mk(0, 0, 0, 0, 0, 0,         0, 0, 0, 0,        0, 0, 0, 0, 0, 0);
        vt[3]  = mk(0, 0, 0, 0, 0, 0,         0, 0, 0, 0,        0, 0, 0, 0, 0, 0);
        vt[4]  = mk(0, 0, 0, 0, 0, 0,         0, 0, 0, 0,        0, 0, 0, 0, 0, 0);
        vt[5]  = mk(0, 0, 0, 0, 0, 3,         0, 0, 0, 0,        1, 32'h1000, 0, 0, 0, 0);
        vt[6]  = mk(0, 0, 0, 0, 0, 3,         0, 0, 0, 0,        0, 0, 0, 0, 0, 0);
        vt[7]  = mk(1, 32'h2000, 0, 0, 0, 0,  1, 0, 0, 0,        0, 0, 0, 0, 0, 0);
        vt[8]  = mk(1, 32'h2004, 0, 0, 6, 0,  1, 0, 1, 32'h2000, 0, 0, 0, 0, 0, 0);
        vt[9]  = mk(1, 32'h2004, 1, 32'hDEADBEEF, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        vt[10] = mk(1, 32'h2004, 1, 32'hDEADBEEF, 0, 6, 1, 0, 0, 0, 1, 32'h2000, 0, 0, 0, 0);
        vt[11] = mk(0, 0, 0, 0, 9, 0,         0, 0, 1, 32'h2000, 0, 0, 0, 0, 0, 0);
        vt[12] = mk(0, 0, 0, 0, 0, 9,         0, 0, 0, 0,        1, 32'h2000, 1, 32'h2004, 32'hDEADBEEF, 0);
        vt[13] = mk(1, 32'h100, 0, 0, 0, 0,   1, 0, 0, 0,        0, 0, 0, 0, 0, 0);
        vt[14] = mk(1, 32'h200, 0, 0, 0, 0,   1, 0, 1, 32'h100,  0, 0, 0, 0, 0, 0);
        vt[15] = mk(1, 32'h300, 0, 0, 1, 0,   1, 0, 1, 32'h100,  0, 0, 0, 0, 0, 0);
        vt[16] = mk(1, 32'h400, 0, 0, 2, 0,   1, 0, 1, 32'h200,  0, 0, 0, 0, 0, 0);
        vt[17] = mk(1, 32'h500, 0, 0, 0, 0,   0, 1, 1, 32'h300,  0, 0, 0, 0, 0, 1);
        vt[18] = mk(1, 32'h500, 0, 0, 0, 2,   0, 1, 1, 32'h300,  1, 32'h200, 0, 0, 0, 1);
        vt[19] = mk(1, 32'h500, 0, 0, 0, 0,   1, 0, 1, 32'h300,  0, 0, 0, 0, 0, 0);

        @(negedge clock);
        do_reset();
        #2;
        check("reset cmd",   proc2mem_command, MEM_NONE);
        check("reset fill",  fill_valid, 0);
        check("reset full",  full, 0);
        check("reset ready", req_ready, 0);
        check("reset stall", stall, 0);
        next();

        // Directed vector table, one row per cycle.
        for (int k = 0; k < NV; k++) begin
            req_valid    = vt[k].v;
            req_addr     = vt[k].a;
            req_is_store = vt[k].st;
            req_data     = vt[k].d;
            req_size     = WORD;
            ttag         = vt[k].tt;
            dtag         = vt[k].dt;
            mdata        = vt[k].md;
            #2;
            check($sformatf("v%0d ready", k), req_ready, vt[k].e_ready);
            check($sformatf("v%0d stall", k), stall, vt[k].e_stall);
            check($sformatf("v%0d cmd", k), proc2mem_command, vt[k].e_cmd);
            check($sformatf("v%0d paddr", k), proc2mem_addr, vt[k].e_paddr);
            check($sformatf("v%0d fill_valid", k), fill_valid, vt[k].e_fv);
            check($sformatf("v%0d fill_addr", k), fill_addr, vt[k].e_faddr);
            check($sformatf("v%0d fill_data", k), fill_data, vt[k].e_fv ? vt[k].md : 64'h0);
            check($sformatf("v%0d fill_is_store", k), fill_is_store, vt[k].e_fst);
            check($sformatf("v%0d fill_st_addr", k), fill_st_addr, vt[k].e_fsa);
            check($sformatf("v%0d fill_st_data", k), fill_st_data, vt[k].e_fsd);
            check($sformatf("v%0d fill_st_size", k), fill_st_size, vt[k].e_fst ? WORD : BYTE);
            check($sformatf("v%0d full", k), full, vt[k].e_full);
            next();
        end
        idle();

        // Issue held while memory returns tag 0, then accepted with tag 7.
        do_reset();
        drive_req(32'h4000, 0, 0, BYTE);
        #2 check("hold alloc ready", req_ready, 1);
        next();
        idle();
        for (int c = 0; c < 3; c++) begin
            ttag = (c == 2) ? MEM_TAG'(7) : MEM_TAG'(0);
            #2;
            check($sformatf("hold cmd c%0d", c), proc2mem_command, MEM_LOAD);
            check($sformatf("hold addr c%0d", c), proc2mem_addr, 32'h4000);
            next();
        end
        idle();
        #2 check("hold cmd after accept", proc2mem_command, MEM_NONE);
        next();
        dtag = 4'd7;
        mdata = 64'h7777_0000_7777_0000;
        #2;
        check("hold fill_valid", fill_valid, 1);
        check("hold fill_addr", fill_addr, 32'h4000);
        next();
        idle();

        // Store miss carrying its payload through to the fill.
        do_reset();
        drive_req(32'h3008, 1, 32'hDEADBEEF, WORD);
        #2 check("store ready", req_ready, 1);
        next();
        idle();
        ttag = 4'd5;
        #2 check("store issue addr", proc2mem_addr, 32'h3008);
        next();
        idle();
        dtag = 4'd5;
        #2;
        check("store fill_is_store", fill_is_store, 1);
        check("store fill_st_addr", fill_st_addr, 32'h3008);
        check("store fill_st_data", fill_st_data, 32'hDEADBEEF);
        check("store fill_st_size", fill_st_size, WORD);
        next();
        idle();

        // Out-of-order responses, then the same with a reset between them.
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            drive_req(32'h5000, 0, 0, BYTE);
            next();
            drive_req(32'h6000, 0, 0, BYTE);
            ttag = 4'd2;
            #2 check($sformatf("ooo%0d issue a", pass), proc2mem_addr, 32'h5000);
            next();
            idle();
            ttag = 4'd4;
            #2 check($sformatf("ooo%0d issue b", pass), proc2mem_addr, 32'h6000);
            next();
            idle();
            dtag = 4'd4;
            #2;
            check($sformatf("ooo%0d fill4 valid", pass), fill_valid, 1);
            check($sformatf("ooo%0d fill4 addr", pass), fill_addr, 32'h6000);
            next();
            idle();
            if (pass == 1) begin
                reset = 1'b1;
                next();
                reset = 1'b0;
            end
            dtag = 4'd2;
            #2;
            check($sformatf("ooo%0d fill2 valid", pass), fill_valid, (pass == 0));
            check($sformatf("ooo%0d fill2 addr", pass), fill_addr, (pass == 0) ? 32'h5000 : 32'h0);
            next();
            idle();
        end

        // Randomized run against the behavioural model.
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_state[i] = 0; m_byte[i] = '0; m_st[i] = 0;
            m_data[i] = '0; m_size[i] = BYTE; m_tag[i] = '0;
        end
        for (int cyc = 0; cyc < 600; cyc++) begin
            int   fidx, fr, pd, sel;
            logic match, e_ready;
            ADDR  a;
            ADDR  e_fsa;
            DATA  e_fsd;
            MEM_SIZE e_fsz;

            a = 32'h8000 + ($urandom_range(0, 5) * 8) + $urandom_range(0, 7);
            req_valid    = ($urandom_range(0, 2) != 0);
            req_addr     = a;
            req_is_store = ($urandom_range(0, 3) == 0);
            req_data     = $urandom;
            req_size     = MEM_SIZE'($urandom_range(0, 3));
            ttag         = ($urandom_range(0, 2) == 0) ? MEM_TAG'(0) : fresh_tag();
            mdata        = {$urandom, $urandom};
            sel          = $urandom_range(0, 3);
            dtag         = '0;
            if (sel == 1) dtag = MEM_TAG'($urandom_range(1, 15));
            if (sel >= 2) begin
                for (int i = 0; i < DEPTH; i++)
                    if (m_state[i] == 2 && (dtag == 0 || $urandom_range(0, 1) == 1))
                        dtag = m_tag[i];
            end

            fidx = -1;
            if (dtag != 0)
                for (int i = DEPTH - 1; i >= 0; i--)
                    if (m_state[i] == 2 && m_tag[i] == dtag) fidx = i;
            match = 0;
            for (int i = 0; i < DEPTH; i++)
                if (m_state[i] != 0 && i != fidx && (m_byte[i] >> 3) == (a >> 3)) match = 1;
            fr = -1;
            pd = -1;
            for (int i = DEPTH - 1; i >= 0; i--) begin
                if (m_state[i] == 0) fr = i;
                if (m_state[i] == 1) pd = i;
            end
            e_ready = req_valid && (match ? !req_is_store : (fr >= 0));
            e_fsa = '0; e_fsd = '0; e_fsz = BYTE;
            if (fidx >= 0 && m_st[fidx]) begin
                e_fsa = m_byte[fidx]; e_fsd = m_data[fidx]; e_fsz = m_size[fidx];
            end

            #2;
            check($sformatf("rnd%0d ready", cyc), req_ready, e_ready);
            check($sformatf("rnd%0d stall", cyc), stall, req_valid && !e_ready);
            check($sformatf("rnd%0d full", cyc), full, (fr < 0));
            check($sformatf("rnd%0d cmd", cyc), proc2mem_command, (pd >= 0) ? MEM_LOAD : MEM_NONE);
            check($sformatf("rnd%0d paddr", cyc), proc2mem_addr,
                  (pd >= 0) ? ((m_byte[pd] >> 3) << 3) : 32'h0);
            check($sformatf("rnd%0d fill_valid", cyc), fill_valid, (fidx >= 0));
            check($sformatf("rnd%0d fill_addr", cyc), fill_addr,
                  (fidx >= 0) ? ((m_byte[fidx] >> 3) << 3) : 32'h0);
            check($sformatf("rnd%0d fill_data", cyc), fill_data, (fidx >= 0) ? mdata : 64'h0);
            check($sformatf("rnd%0d fill_is_store", cyc), fill_is_store, (fidx >= 0) && m_st[fidx]);
            check($sformatf("rnd%0d fill_st_addr", cyc), fill_st_addr, e_fsa);
            check($sformatf("rnd%0d fill_st_data", cyc), fill_st_data, e_fsd);
            check($sformatf("rnd%0d fill_st_size", cyc), fill_st_size, e_fsz);

            if (fidx >= 0) m_state[fidx] = 0;
            if (pd >= 0 && ttag != 0) begin
                m_state[pd] = 2;
                m_tag[pd]   = ttag;
            end
            if (req_valid && !match && fr >= 0) begin
                m_state[fr] = 1;
                m_byte[fr]  = a;
                m_st[fr]    = req_is_store;
                m_data[fr]  = req_data;
                m_size[fr]  = req_size;
            end
            for (int i = 0; i < DEPTH; i++)
                for (int j = i + 1; j < DEPTH; j++)
                    assert (!(m_state[i] == 2 && m_state[j] == 2 && m_tag[i] == m_tag[j]))
                        else $error("duplicate waiting tag %0d", m_tag[i]);
            next();
        end
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mshr_file.md
Name: mshr_file

Overview:
- Multi-entry, non-blocking miss status holding register file between the D-cache and the memory interface.
- Tracks up to MSHR_DEPTH outstanding block misses at once; issues one memory load per cycle.
- Merges later load misses to an already-tracked block; matches memory responses by transaction tag.
- Returns each fill, plus any pending store payload, to the D-cache so load/store units stall only when no entry is available.

Parameters:
- MSHR_DEPTH, 4, number of miss entries (power of two, 2..16).
- BLOCK_OFFSET_BITS, 3, low address bits ignored for block matching (8-byte block).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  D-cache miss presented this cycle
- req_addr  in  ADDR  miss byte address
- req_is_store  in  1  miss is a store
- req_data  in  DATA  store data
- req_size  in  MEM_SIZE  store size
- req_ready  out  1  request accepted this cycle (allocated or merged)
- proc2mem_command  out  MEM_COMMAND  MEM_LOAD when issuing, else MEM_NONE
- proc2mem_addr  out  ADDR  block-aligned address of the issuing entry
- mem2proc_transaction_tag  in  MEM_TAG  nonzero = issued request accepted with this tag
- mem2proc_data_tag  in  MEM_TAG  nonzero = response data for this tag
- mem2proc_data  in  MEM_BLOCK  response block
- fill_valid  out  1  one-cycle fill pulse to the D-cache
- fill_addr  out  ADDR  block-aligned fill address
- fill_data  out  MEM_BLOCK  fill block
- fill_is_store  out  1  fill carries a store to apply
- fill_st_addr  out  ADDR  full byte address of that store
- fill_st_data  out  DATA  store data
- fill_st_size  out  MEM_SIZE  store size
- full  out  1  all entries valid
- stall  out  1  req_valid && !req_ready

Behaviour:
- Entry fields: state, block addr, byte addr, is_store, st_data, st_size, mem_tag.
- Entry states: INVALID -> PENDING (allocated) -> WAITING (issued, tag held) -> INVALID (filled).
- Reset: every entry INVALID with all fields zero. All outputs zero/MEM_NONE in the cycle after reset. Reset mid-operation drops all entries; late responses are ignored.
- Match: compare req_addr[31:BLOCK_OFFSET_BITS] against every non-INVALID entry, excluding an entry retiring this cycle.
- Load + match: merge. req_ready=1 and no new entry is allocated.
- Store + match: req_ready=0 until the matching entry retires. Stores never merge.
- No match: allocate the lowest-index INVALID entry as PENDING. req_ready=1 if one exists, else 0.
- A slot freed by a fill becomes allocatable the next cycle, not the same cycle.
- Issue (combinational, at most one per cycle): choose the lowest-index PENDING entry and drive MEM_LOAD with its block address.
  - If mem2proc_transaction_tag != 0 in the same cycle, the entry moves to WAITING and stores that tag.
  - If the tag is 0, the entry stays PENDING and re-drives next cycle.
- A newly allocated entry cannot issue in its allocation cycle; earliest issue is the next cycle.
- Fill (combinational): when mem2proc_data_tag != 0 and equals the mem_tag of a WAITING entry:
  - fill_valid=1 that cycle; fill_addr, fill_data=mem2proc_data, and the entry's store fields are driven.
  - The entry returns to INVALID at the clock edge.
  - fill_is_store=0 when the entry is a load; store fields are then zero.
- A data tag of 0, or a tag matching no entry, is ignored.
- Issue, fill and allocation may all occur in one cycle, each on different entries.
- full = all entries non-INVALID, registered-state based.
- Latency:
  - Miss accepted at cycle t -> MEM_LOAD issued no earlier than t+1.
  - Fill appears in the same cycle as the matching data tag.
- Tags are unique among WAITING entries by memory contract. The design does not check this; the bench asserts it.

Decomposition:
- Shared package (sys_defs): MSHR_STATE enum {MSHR_INVALID, MSHR_PENDING, MSHR_WAITING}, MSHR_ENTRY struct, MSHR_DEPTH default.
- Debug port exports the MSHR_ENTRY [MSHR_DEPTH] array under DEBUG.
- One sub-module: mshr_lsb_select, a parametrised lowest-set-bit selector returning a one-hot vector and a valid bit. Instantiate it twice: free-entry selection and pending-issue selection.

Test Plan:
- Single load miss 0x1004 at t0; at t1 transaction_tag=3; at t5 data_tag=3 -> MEM_LOAD with addr 0x1000 at t1; fill_valid at t5 with fill_addr 0x1000, fill_is_store=0; entry INVALID at t6.
- Fill MSHR_DEPTH=4 misses to 0x100, 0x200, 0x300, 0x400 -> full=1. Fifth miss 0x500 -> req_ready=0, stall=1. A fill of any entry frees a slot; 0x500 is accepted the following cycle.
- Loads to 0x2000 then 0x2004 -> one entry, one MEM_LOAD. Store to 0x2004 -> stall until the 0x2000 fill, then allocated as a new entry.
- Issue cycle with transaction_tag=0 for 2 cycles, then 7 -> MEM_LOAD held for 3 cycles on the same address; entry WAITING with tag 7.
- Store miss 0x3008, size WORD, data 0xDEADBEEF, tag 5; response tag 5 -> fill_is_store=1, fill_st_addr 0x3008, fill_st_data 0xDEADBEEF, fill_st_size WORD.
- Two entries WAITING with tags 2 and 4; responses arrive in order 4 then 2 -> fills come out of order with the correct addresses. Reset asserted between the two responses -> no fill for the second one.
